// File: rtl/mem_burst_arbiter.sv
// Three-requester round-robin arbiter that multiplexes 1..8 beat read/write bursts
// onto a single-port synchronous RAM with one-cycle read latency.
module mem_burst_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [2:0]            req_we,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [8:0]            req_len,
    input  logic [3*DATA_W-1:0]   req_wdata,
    output logic [2:0]            grant,
    output logic [2:0]            ack,
    output logic [2:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_di,
    input  logic [DATA_W-1:0]     mem_do
);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t              state;
    logic [1:0]          owner;
    logic [1:0]          last_owner;
    logic [1:0]          pick;
    logic                we_q;
    logic [ADDR_W-1:0]   start_q;
    logic [2:0]          len_q;
    logic [2:0]          beat;
    logic [2:0]          next_beat;
    logic [ADDR_W-1:0]   pick_addr;
    logic [2:0]          pick_len;

    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] sel;
        logic       found;
        sel   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (int'(last) + 1 + k) % 3;
            if (!found && r[idx]) begin
                sel   = 2'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    assign pick      = rr_pick(req, last_owner);
    assign pick_addr = req_addr[int'(pick)*ADDR_W +: ADDR_W];
    assign pick_len  = req_len[int'(pick)*3 +: 3];
    assign next_beat = beat + 3'd1;
    assign rdata     = mem_do;

    always_comb begin
        mem_di = '0;
        if (|grant)
            mem_di = req_wdata[int'(owner)*DATA_W +: DATA_W];
    end

    // Registered outputs describe the beat currently on the RAM port; each edge
    // decides the next beat. Write acks coincide with the strobe, read acks lag
    // the issue by the RAM latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 3'b000;
            ack        <= 3'b000;
            done       <= 3'b000;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            beat       <= 3'd0;
            owner      <= 2'd0;
            last_owner <= 2'd2;
        end else begin
            ack  <= 3'b000;
            done <= 3'b000;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner      <= pick;
                        last_owner <= pick;
                        grant      <= onehot(pick);
                        we_q       <= req_we[pick];
                        start_q    <= pick_addr;
                        len_q      <= pick_len;
                        beat       <= 3'd0;
                        mem_en     <= 1'b1;
                        mem_we     <= req_we[pick];
                        mem_addr   <= pick_addr;
                        if (req_we[pick]) begin
                            ack  <= onehot(pick);
                            done <= (pick_len == 3'd0) ? onehot(pick) : 3'b000;
                        end
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        // Owner withdrew: stop issuing, still return an in-flight read beat.
                        state  <= DRAIN;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (!we_q)
                            ack <= grant;
                    end else if (beat == len_q) begin
                        state  <= DRAIN;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (!we_q) begin
                            ack  <= grant;
                            done <= grant;
                        end
                    end else begin
                        beat     <= next_beat;
                        mem_addr <= start_q + ADDR_W'(next_beat);
                        ack      <= grant;
                        if (we_q && next_beat == len_q)
                            done <= grant;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    grant <= 3'b000;
                    beat  <= 3'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter with a behavioural one-cycle-latency RAM.
module tb_mem_burst_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [2:0]          req = 3'b000;
    logic [2:0]          req_we = 3'b000;
    logic [3*ADDR_W-1:0] req_addr = '0;
    logic [8:0]          req_len = '0;
    logic [3*DATA_W-1:0] req_wdata = '0;
    logic [2:0]          grant, ack, done;
    logic [DATA_W-1:0]   rdata, mem_di;
    logic [DATA_W-1:0]   mem_do;
    logic                mem_en, mem_we;
    logic [ADDR_W-1:0]   mem_addr;

    logic [DATA_W-1:0]   ram [0:1023];
    logic [DATA_W-1:0]   wbuf [0:7];
    int                  n_checks = 0;
    int                  n_errors = 0;

    mem_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata), .grant(grant), .ack(ack), .done(done),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_di(mem_di), .mem_do(mem_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_di;
        if (mem_en) mem_do <= ram[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a, input logic [2:0] l);
        req[i]                   = 1'b1;
        req_we[i]                = we;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_len[i*3 +: 3]        = l;
    endtask

    // Cycle 0 is the calling cycle; issue cycles 1..L+1, DRAIN L+2, IDLE L+3.
    task automatic burst(input int i, input logic we, input logic [ADDR_W-1:0] a, input logic [2:0] l);
        logic [2:0]        oh;
        logic [ADDR_W-1:0] ea;
        int                L;
        L  = int'(l);
        oh = 3'b001 << i;
        set_req(i, we, a, l);
        req_wdata[i*DATA_W +: DATA_W] = wbuf[0];
        for (int n = 1; n <= L + 3; n++) begin
            @(posedge clk); #1;
            if (we && n <= L + 1) req_wdata[i*DATA_W +: DATA_W] = wbuf[n-1];
            #1;
            if (n <= L + 1) begin
                ea = a + ADDR_W'(n - 1);
                check("burst_grant", 64'(grant), 64'(oh));
                check("burst_mem_en", 64'(mem_en), 64'd1);
                check("burst_mem_we", 64'(mem_we), 64'(we));
                check("burst_mem_addr", 64'(mem_addr), 64'(ea));
                check("burst_ack", 64'(ack), (we || n > 1) ? 64'(oh) : 64'd0);
                check("burst_done", 64'(done), (we && n == L + 1) ? 64'(oh) : 64'd0);
                if (we) check("burst_mem_di", 64'(mem_di), 64'(wbuf[n-1]));
            end else if (n == L + 2) begin
                check("drain_grant", 64'(grant), 64'(oh));
                check("drain_mem_en", 64'(mem_en), 64'd0);
                check("drain_ack", 64'(ack), we ? 64'd0 : 64'(oh));
                check("drain_done", 64'(done), we ? 64'd0 : 64'(oh));
            end else begin
                check("idle_grant", 64'(grant), 64'd0);
                check("idle_mem_en", 64'(mem_en), 64'd0);
                check("idle_ack", 64'(ack), 64'd0);
                check("idle_done", 64'(done), 64'd0);
            end
            if (!we && n >= 2 && n <= L + 2)
                check("read_rdata", 64'(rdata), 64'(wbuf[n-2]));
            if (n == L + 2) req[i] = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]        oh;
        logic [DATA_W-1:0] rd_exp [0:2];
        int                ack_cnt;
        int                done_cnt;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        reset = 1'b1;

        // Write then read back three words at 0x010 (first grant right after reset release).
        wbuf = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        burst(0, 1'b1, 10'h010, 3'd2);
        burst(0, 1'b0, 10'h010, 3'd2);

        // Write across the top of the address space and read it back.
        wbuf = '{32'hA5A5_03FE, 32'hA5A5_03FF, 32'hA5A5_0000, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0, 32'h0};
        burst(1, 1'b1, 10'h3FE, 3'd3);
        burst(1, 1'b0, 10'h3FE, 3'd3);

        wbuf[0] = 32'hC0DE_0200;
        burst(2, 1'b1, 10'h200, 3'd0);

        // Fairness: all three request single-beat reads continuously.
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 10'h010, 3'd0);
        for (int c = 1; c <= 12; c++) begin
            int b;
            int ph;
            @(posedge clk); #2;
            b  = (c - 1) / 3;
            ph = (c - 1) % 3;
            oh = 3'b001 << (b % 3);
            check("rr_grant", 64'(grant), (ph < 2) ? 64'(oh) : 64'd0);
            check("rr_mem_en", 64'(mem_en), (ph == 0) ? 64'd1 : 64'd0);
            check("rr_ack", 64'(ack), (ph == 1) ? 64'(oh) : 64'd0);
            check("rr_done", 64'(done), (ph == 1) ? 64'(oh) : 64'd0);
            if (c == 11) req = 3'b000;
        end

        // Abort: 8-beat read withdrawn during the third issue cycle.
        rd_exp   = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        ack_cnt  = 0;
        done_cnt = 0;
        set_req(0, 1'b0, 10'h010, 3'd7);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #2;
            ack_cnt  += int'(ack[0]);
            done_cnt += int'(done[0]);
            check("abort_grant", 64'(grant), (c <= 4) ? 64'd1 : 64'd0);
            check("abort_mem_en", 64'(mem_en), (c <= 3) ? 64'd1 : 64'd0);
            check("abort_ack", 64'(ack), (c >= 2 && c <= 4) ? 64'd1 : 64'd0);
            if (c <= 3) check("abort_mem_addr", 64'(mem_addr), 64'(10'h010 + 10'(c - 1)));
            if (c >= 2 && c <= 4) check("abort_rdata", 64'(rdata), 64'(rd_exp[c-2]));
            if (c == 3) req[0] = 1'b0;
        end
        check("abort_ack_count", 64'(ack_cnt), 64'd3);
        check("abort_done_count", 64'(done_cnt), 64'd0);

        // Reset during beat 2 of a write, then requesters 1 and 2 compete.
        set_req(0, 1'b1, 10'h100, 3'd5);
        req_wdata[0 +: DATA_W] = 32'hDEAD_0000;
        repeat (3) begin
            @(posedge clk); #2;
        end
        check("mid_mem_addr", 64'(mem_addr), 64'h102);
        check("mid_ack", 64'(ack), 64'd1);
        reset = 1'b0;
        @(posedge clk); #2;
        check("mrst_grant", 64'(grant), 64'd0);
        check("mrst_ack", 64'(ack), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_mem_en", 64'(mem_en), 64'd0);
        check("mrst_mem_we", 64'(mem_we), 64'd0);
        check("mrst_mem_addr", 64'(mem_addr), 64'd0);
        check("mrst_mem_di", 64'(mem_di), 64'd0);
        reset = 1'b1;
        req[0] = 1'b0;
        set_req(1, 1'b0, 10'h020, 3'd0);
        set_req(2, 1'b0, 10'h030, 3'd0);
        @(posedge clk); #2;
        check("post_rst_grant", 64'(grant), 64'b010);
        check("post_rst_mem_en", 64'(mem_en), 64'd1);
        @(posedge clk); #2;
        check("post_rst_ack", 64'(ack), 64'b010);
        check("post_rst_done", 64'(done), 64'b010);
        req[1] = 1'b0;
        @(posedge clk); #2;
        check("post_rst_idle", 64'(grant), 64'd0);
        @(posedge clk); #2;
        check("post_rst_grant2", 64'(grant), 64'b100);
        check("post_rst_addr2", 64'(mem_addr), 64'h030);
        @(posedge clk); #2;
        req[2] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("final_idle", 64'(grant), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_burst_arbiter.md
MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

Interface
REQ-001 Parameter ADDR_W, 10, RAM word-address width.
REQ-002 Parameter DATA_W, 32, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 req  input  3  per-requester burst request, bit i = requester i; held high until done[i].
REQ-006 req_we  input  3  per-requester direction, 1 = write burst, 0 = read burst.
REQ-007 req_addr  input  3*ADDR_W  start word address; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 req_len  input  9  burst length minus one (1..8 beats); requester i at bits [i*3 +: 3].
REQ-009 req_wdata  input  3*DATA_W  write data for the current beat; requester i at bits [i*DATA_W +: DATA_W].
REQ-010 grant  output  3  one-hot owner of the RAM port; 000 when idle.
REQ-011 ack  output  3  one-cycle pulse per completed beat to the owner.
REQ-012 done  output  3  one-cycle pulse to the owner on its last beat, coincident with that beat's ack.
REQ-013 rdata  output  DATA_W  read data; equals mem_do; valid when ack is high on a read burst.
REQ-014 mem_en, mem_we  output  1 each  RAM enable and write strobe.
REQ-015 mem_addr  output  ADDR_W  RAM address, registered.
REQ-016 mem_di  output  DATA_W  RAM write data; combinationally equals the owner's req_wdata slice; 0 when not granted.
REQ-017 mem_do  input  DATA_W  RAM read data; one-cycle read latency (address at edge t, data valid during cycle t+1).

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BURST, DRAIN.
REQ-019 In IDLE with any req bit high, the block SHALL select one requester round-robin, searching from (last_owner+1) mod 3 upward, and SHALL latch its we, addr and len; next state is BURST.
REQ-020 In IDLE with req = 000, the FSM SHALL stay in IDLE, and grant, mem_en and mem_we SHALL be 0.
REQ-021 In BURST, the registered grant SHALL be the one-hot owner, mem_en SHALL be 1, mem_we SHALL equal the latched we, and mem_addr SHALL equal start + beat.
REQ-022 The beat counter SHALL start at 0 and increment once per BURST cycle.
REQ-023 Address arithmetic SHALL be modulo 2^ADDR_W (0x3FF + 1 wraps to 0x000).
REQ-024 Write burst: ack SHALL pulse in each BURST cycle, the same cycle mem_we is high; the requester presents beat k+1 data in the cycle after beat k's ack.
REQ-025 Read burst: ack SHALL pulse in the cycle after each BURST issue cycle, so the last read ack falls in DRAIN.
REQ-026 After issuing beat len, BURST SHALL go to DRAIN; DRAIN SHALL last one cycle with mem_en = 0 and grant held, then go to IDLE.
REQ-027 last_owner SHALL update when the grant is latched.
REQ-028 A request arriving while the RAM is busy SHALL wait.
REQ-029 Minimum bus turnaround SHALL be two cycles without mem_en (DRAIN, then IDLE).
REQ-030 If the owner's req drops during BURST, the block SHALL issue no further beats, SHALL go to DRAIN, and SHALL still deliver the ack of an already-issued read beat, but SHALL NOT assert done.
REQ-031 Requests from non-owners SHALL never cause ack or done on their bits.
REQ-032 At most one bit of grant, ack or done SHALL be high in any cycle.

Reset
REQ-033 While reset = 0, the block SHALL force state IDLE, grant = ack = done = 000, mem_en = mem_we = 0, mem_addr = 0, beat = 0, last_owner = 2 (so requester 0 wins first).
REQ-034 Reset asserted mid-burst SHALL abort the burst with no further ack or done.
REQ-035 The first grant SHALL be possible in the cycle after reset returns to 1.

Verification
REQ-036 Read: req=001, we=0, addr=0x010, len=2 -> grant=001 in cycles 1-4; mem_addr 0x010/0x011/0x012 in cycles 1-3; ack[0] in cycles 2-4; done[0] in cycle 4; rdata = RAM contents.
REQ-037 Write: req=010, we=1, addr=0x3FE, len=3 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 written with the presented data; ack[1] in each write cycle; done[1] with the 4th ack.
REQ-038 Fairness: req=111 held, len=0 for all -> grant order 001, 010, 100, 001, with two idle cycles between bursts.
REQ-039 Abort: read len=7, drop req[0] after the 3rd issue -> exactly 3 acks, no done, then DRAIN, then IDLE.
REQ-040 Reset: assert reset during beat 2 of a write -> next cycle all outputs 0; after release with req=110, requester 1 is granted first.
